autosym_space_probe: RTL

Sequential probe that drives the primary inputs of a combinational single-output benchmark netlist (inputs x0..x{N-1}, output y0), records its complete truth table, then computes the function's autosymmetry space L_f = { a : f(x ⊕ a) = f(x) for all x } and its degree k = log2|L_f|. It is the stimulus/readback end of the benchmark netlists. It sits in the verification harness next to one netlist instance and hands the truth table and L_f to the reporting logic.

---
 rtl/autosym_space_probe_if.sv | 18 +
 rtl/autosym_space_probe.sv | 112 +++++++++++
 2 files changed

// File: rtl/autosym_space_probe_if.sv
// Probe-side bundle: netlist drive/readback, the start/done request pair and results.
// start is a request honoured only when busy=0; done pulses for one cycle when tt, lspace and dim are final.
interface autosym_space_probe_if #(parameter int N = 7);
  logic                  start;
  logic                  y_in;
  logic [N-1:0]          x;
  logic                  busy;
  logic                  done;
  logic [(1<<N)-1:0]     tt;
  logic [(1<<N)-1:0]     lspace;
  logic [3:0]            dim;
  logic [1:0]            dbg_state;

  modport master (output start, y_in,
                  input  x, busy, done, tt, lspace, dim, dbg_state);
  modport slave  (input  start, y_in,
                  output x, busy, done, tt, lspace, dim, dbg_state);
endinterface

// File: rtl/autosym_space_probe.sv
// Sweeps a single-output netlist to capture its truth table, then finds the autosymmetry
// space L_f = { a : f(x^a) = f(x) } and its degree k = log2|L_f|.
module autosym_space_probe #(
  parameter int N = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  autosym_space_probe_if.slave bus
);
  localparam int TW = 1 << N;
  localparam logic [N-1:0] ONE_N = 1;
  localparam logic [N-1:0] ALL_N = {N{1'b1}};
  localparam logic [N:0]   ONE_M = 1;

  typedef enum logic [1:0] {IDLE, SWEEP, SCAN, FINISH} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    idx, a, j;
  logic [N:0]      mcnt, mcnt_nxt;
  logic [TW-1:0]   tt_q, ls_q;
  logic [3:0]      dim_q;
  logic            mismatch, last_j, last_a, cand_done;

  // mcnt is |L_f| and always a power of two, so its set bit position is k
  function automatic logic [3:0] onehot_pos(input logic [N:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i <= N; i++) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  assign mismatch  = (tt_q[j] != tt_q[j ^ a]);
  assign last_j    = (j == ALL_N);
  assign last_a    = (a == ALL_N);
  assign cand_done = mismatch || last_j;
  assign mcnt_nxt  = (!mismatch && last_j) ? (mcnt + ONE_M) : mcnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SWEEP;
      SWEEP:   if (idx == ALL_N) state_nxt = SCAN;
      SCAN:    if (cand_done && last_a) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      a     <= '0;
      j     <= '0;
      mcnt  <= '0;
      tt_q  <= '0;
      ls_q  <= '0;
      dim_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            idx   <= '0;
            a     <= '0;
            j     <= '0;
            mcnt  <= '0;
            tt_q  <= '0;
            ls_q  <= '0;
            dim_q <= '0;
          end
        end
        SWEEP: begin
          tt_q[idx] <= bus.y_in;
          idx       <= idx + ONE_N;
          if (idx == ALL_N) begin
            a       <= ONE_N;
            j       <= '0;
            ls_q[0] <= 1'b1;
            mcnt    <= ONE_M;
          end
        end
        SCAN: begin
          // a mismatch ends the candidate early; a full match admits it into L_f
          if (!mismatch && last_j) ls_q[a] <= 1'b1;
          mcnt <= mcnt_nxt;
          if (cand_done) begin
            a <= a + ONE_N;
            j <= '0;
            if (last_a) dim_q <= onehot_pos(mcnt_nxt);
          end else begin
            j <= j + ONE_N;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.x         = (state == SWEEP) ? idx : '0;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == FINISH);
  assign bus.tt        = tt_q;
  assign bus.lspace    = ls_q;
  assign bus.dim       = dim_q;
  assign bus.dbg_state = state;
endmodule
